jtkcpu_useq: RTL and testbench

Parametrised microcode address sequencer for the KCPU family. It replaces the fixed single-level category jump with the following:
- a return-address stack of configurable depth, for nested ucode subroutines;
- NINT prioritised interrupt sources, each individually edge- or level-sensitive;
- sticky stack error flags.

It drives the address of the external ucode ROM and sits between the opcode-to-category decoder and the ucode memory.

---
 rtl/jtkcpu_useq.sv | 177 +++++++++++++++++
 tb/tb_jtkcpu_useq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_useq.sv
// jtkcpu_useq: microcode address sequencer for the KCPU family.
// Generates the ucode ROM address with a return stack and prioritised interrupt entry.
module jtkcpu_useq #(
    parameter int              AW       = 10,
    parameter int              CW       = 6,
    parameter int              NINT     = 3,
    parameter logic [NINT-1:0] EDGE     = 3'b100,
    parameter int              SDEPTH   = 4,
    parameter int              RST_CAT  = 0,
    parameter int              INT_BASE = 1,
    parameter int              ERR_CAT  = 63
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cen,
    input  logic                         halt,
    input  logic                         stall,
    input  logic [CW-1:0]                op_cat,
    input  logic                         ni,
    input  logic                         jmp,
    input  logic [CW-1:0]                jmp_cat,
    input  logic                         call,
    input  logic [CW-1:0]                call_cat,
    input  logic                         ret,
    input  logic [NINT-1:0]              int_rq,
    input  logic [NINT-1:0]              int_mask,
    output logic [AW-1:0]                addr,
    output logic [NINT-1:0]              cur_int,
    output logic                         intsrv,
    output logic [$clog2(SDEPTH+1)-1:0]  sdepth,
    output logic                         stk_ovf,
    output logic                         stk_unf
);

    localparam int SW = $clog2(SDEPTH+1);
    localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [SW-1:0] FULL = SW'(SDEPTH);

    typedef enum logic [2:0] {
        A_HOLD,
        A_INC,
        A_NI,
        A_RET,
        A_CALL,
        A_JMP
    } act_e;

    function automatic logic [AW-1:0] cat_addr(input logic [CW-1:0] c);
        return {c, {(AW-CW){1'b0}}};
    endfunction

    logic [NINT-1:0] pending;
    logic [NINT-1:0] hist;
    logic [NINT-1:0] new_edge;
    logic [NINT-1:0] act;
    logic [NINT-1:0] int_oh;
    logic [CW-1:0]   int_cat;
    logic [AW-1:0]   stk [SDEPTH];
    logic [AW-1:0]   addr_inc;
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   pop_idx;
    act_e            act_sel;

    logic [AW-1:0]   addr_nx;
    logic [NINT-1:0] cur_int_nx;
    logic [NINT-1:0] pend_nx;
    logic [SW-1:0]   sp_nx;
    logic            ovf_nx;
    logic            unf_nx;
    logic            push;

    assign new_edge = int_rq & ~hist & EDGE;
    assign act      = (pending | (int_rq & ~EDGE)) & ~int_mask;
    assign intsrv   = |act;
    assign addr_inc = addr + AW'(1);
    assign push_idx = IW'(sdepth);
    assign pop_idx  = IW'(sdepth - SW'(1));

    // Highest set index wins, so later loop iterations override earlier ones.
    always_comb begin
        int_oh  = '0;
        int_cat = '0;
        for (int k = 0; k < NINT; k++) begin
            if (act[k]) begin
                int_oh    = '0;
                int_oh[k] = 1'b1;
                int_cat   = CW'(INT_BASE + k);
            end
        end
    end

    always_comb begin
        if (jmp)
            act_sel = A_JMP;
        else if (call)
            act_sel = A_CALL;
        else if (ret)
            act_sel = A_RET;
        else if (ni)
            act_sel = A_NI;
        else if (!stall)
            act_sel = A_INC;
        else
            act_sel = A_HOLD;
    end

    always_comb begin
        addr_nx    = addr;
        cur_int_nx = cur_int;
        pend_nx    = pending | new_edge;
        sp_nx      = sdepth;
        ovf_nx     = stk_ovf;
        unf_nx     = stk_unf;
        push       = 1'b0;
        case (act_sel)
            A_JMP: addr_nx = cat_addr(jmp_cat);
            A_CALL: begin
                addr_nx = cat_addr(call_cat);
                if (sdepth == FULL) begin
                    ovf_nx = 1'b1;
                end else begin
                    push  = 1'b1;
                    sp_nx = sdepth + SW'(1);
                end
            end
            A_RET: begin
                if (sdepth == '0) begin
                    unf_nx  = 1'b1;
                    addr_nx = cat_addr(CW'(ERR_CAT));
                end else begin
                    addr_nx = stk[pop_idx];
                    sp_nx   = sdepth - SW'(1);
                end
            end
            A_NI: begin
                if (|act) begin
                    addr_nx    = cat_addr(int_cat);
                    cur_int_nx = int_oh;
                    // A fresh edge on the dispatch cycle keeps the source pending.
                    pend_nx    = (pending & ~int_oh) | new_edge;
                end else begin
                    addr_nx    = cat_addr(op_cat);
                    cur_int_nx = '0;
                end
            end
            A_INC:   addr_nx = addr_inc;
            default: addr_nx = addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= cat_addr(CW'(RST_CAT));
            cur_int <= '0;
            pending <= '0;
            hist    <= '0;
            sdepth  <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (cen && !halt) begin
            addr    <= addr_nx;
            cur_int <= cur_int_nx;
            pending <= pend_nx;
            hist    <= int_rq;
            sdepth  <= sp_nx;
            stk_ovf <= ovf_nx;
            stk_unf <= unf_nx;
        end
    end

    // Stack storage needs no reset: occupancy is what makes entries valid.
    always_ff @(posedge clk) begin
        if (!rst && cen && !halt && push)
            stk[push_idx] <= addr_inc;
    end

endmodule

// File: tb/tb_jtkcpu_useq.sv
// Testbench for jtkcpu_useq: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the sequencer.
module tb_jtkcpu_useq;

    localparam int AW = 10, CW = 6, SDEPTH = 4;
    localparam int RST_CAT = 0, INT_BASE = 1, ERR_CAT = 63;
    localparam logic [2:0] EDGE = 3'b100;
    localparam int ROWS = 1 << (AW - CW);
    localparam int AMOD = 1 << AW;

    logic       clk = 1'b0;
    logic       rst, cen, halt, stall, ni, jmp, call, ret;
    logic [5:0] op_cat, jmp_cat, call_cat;
    logic [2:0] int_rq, int_mask;
    logic [9:0] addr;
    logic [2:0] cur_int;
    logic       intsrv;
    logic [2:0] sdepth;
    logic       stk_ovf, stk_unf;

    int checks = 0;
    int errors = 0;

    int         m_addr;
    int         m_stack[$];
    logic [2:0] m_pend, m_prev, m_cur;
    logic       m_ovf, m_unf;

    jtkcpu_useq dut (
        .clk(clk), .rst(rst), .cen(cen), .halt(halt), .stall(stall),
        .op_cat(op_cat), .ni(ni), .jmp(jmp), .jmp_cat(jmp_cat),
        .call(call), .call_cat(call_cat), .ret(ret),
        .int_rq(int_rq), .int_mask(int_mask),
        .addr(addr), .cur_int(cur_int), .intsrv(intsrv),
        .sdepth(sdepth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    task automatic model_tick();
        logic [2:0] edges, act, npend;
        int k;
        if (rst) begin
            m_addr = RST_CAT * ROWS;
            m_stack.delete();
            m_pend = '0; m_prev = '0; m_cur = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (cen && !halt) begin
            edges = int_rq & ~m_prev & EDGE;
            act   = (m_pend | (int_rq & ~EDGE)) & ~int_mask;
            npend = m_pend | edges;
            if (jmp) begin
                m_addr = jmp_cat * ROWS;
            end else if (call) begin
                if (m_stack.size() == SDEPTH) m_ovf = 1'b1;
                else m_stack.push_back((m_addr + 1) % AMOD);
                m_addr = call_cat * ROWS;
            end else if (ret) begin
                if (m_stack.size() == 0) begin
                    m_unf = 1'b1;
                    m_addr = ERR_CAT * ROWS;
                end else m_addr = m_stack.pop_back();
            end else if (ni) begin
                if (act != 0) begin
                    k = 0;
                    for (int i = 0; i < 3; i++) if (act[i]) k = i;
                    m_addr = ((INT_BASE + k) % 64) * ROWS;
                    m_cur  = 3'(1 << k);
                    if (!edges[k]) npend[k] = 1'b0;
                end else begin
                    m_addr = op_cat * ROWS;
                    m_cur  = '0;
                end
            end else if (!stall) begin
                m_addr = (m_addr + 1) % AMOD;
            end
            m_pend = npend;
            m_prev = int_rq;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        rst = 0; cen = 1; halt = 0; stall = 0;
        ni = 0; jmp = 0; call = 0; ret = 0;
        jmp_cat = 0; call_cat = 0;
        int_rq = 0; int_mask = 0;
    endtask

    task automatic test_reset();
        idle();
        op_cat = 6'd5;
        int_rq = 3'b100;
        rst = 1; step(); step(); rst = 0;
        checks++; if (addr !== 10'(RST_CAT * ROWS)) begin errors++; $display("FAIL reset_addr: got %h expected %h", addr, 10'(RST_CAT * ROWS)); end
        checks++; if (cur_int !== 3'b000) begin errors++; $display("FAIL reset_cur_int: got %b expected 000", cur_int); end
        checks++; if (sdepth !== 3'd0) begin errors++; $display("FAIL reset_sdepth: got %0d expected 0", sdepth); end
        checks++; if (stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", stk_ovf, stk_unf); end
        step();
        checks++; if (addr !== 10'h001) begin errors++; $display("FAIL inc1: got %h expected 001", addr); end
        step();
        checks++; if (addr !== 10'h002) begin errors++; $display("FAIL inc2: got %h expected 002", addr); end
        // Request held through reset is seen as an edge on the first cen cycle.
        ni = 1; step(); ni = 0; int_rq = 0;
        checks++; if (addr !== 10'((INT_BASE + 2) * ROWS) || cur_int !== 3'b100) begin errors++; $display("FAIL rst_held_edge: got %h/%b expected %h/100", addr, cur_int, 10'((INT_BASE + 2) * ROWS)); end
        ni = 1; step(); ni = 0;
        checks++; if (addr !== 10'(5 * ROWS) || cur_int !== 3'b000) begin errors++; $display("FAIL ni_opcode: got %h/%b expected %h/000", addr, cur_int, 10'(5 * ROWS)); end
    endtask

    task automatic test_calls();
        idle();
        jmp = 1; jmp_cat = 6'd5; step(); jmp = 0;
        step(); step(); step();
        checks++; if (addr !== 10'h053) begin errors++; $display("FAIL pre_call: got %h expected 053", addr); end
        call = 1; call_cat = 6'd7; step(); call = 0;
        checks++; if (addr !== 10'h070 || sdepth !== 3'd1) begin errors++; $display("FAIL call1: got %h d=%0d expected 070 d=1", addr, sdepth); end
        step();
        call = 1; call_cat = 6'd9; step(); call = 0;
        checks++; if (addr !== 10'h090 || sdepth !== 3'd2) begin errors++; $display("FAIL call2: got %h d=%0d expected 090 d=2", addr, sdepth); end
        ret = 1; step();
        checks++; if (addr !== 10'h072 || sdepth !== 3'd1) begin errors++; $display("FAIL ret1: got %h d=%0d expected 072 d=1", addr, sdepth); end
        step(); ret = 0;
        checks++; if (addr !== 10'h054 || sdepth !== 3'd0) begin errors++; $display("FAIL ret2: got %h d=%0d expected 054 d=0", addr, sdepth); end
        call = 1; call_cat = 6'd10;
        for (int i = 0; i < SDEPTH; i++) step();
        checks++; if (sdepth !== 3'(SDEPTH) || stk_ovf !== 1'b0) begin errors++; $display("FAIL fill: got d=%0d ovf=%b expected d=%0d ovf=0", sdepth, stk_ovf, SDEPTH); end
        call_cat = 6'd11; step(); call = 0;
        checks++; if (addr !== 10'h0B0 || stk_ovf !== 1'b1 || sdepth !== 3'(SDEPTH)) begin errors++; $display("FAIL overflow: got %h ovf=%b d=%0d expected 0B0 ovf=1 d=%0d", addr, stk_ovf, sdepth, SDEPTH); end
        ret = 1;
        for (int i = 0; i < SDEPTH; i++) step();
        checks++; if (addr !== 10'h055 || sdepth !== 3'd0) begin errors++; $display("FAIL unwind: got %h d=%0d expected 055 d=0", addr, sdepth); end
        step(); ret = 0;
        checks++; if (addr !== 10'(ERR_CAT * ROWS) || stk_unf !== 1'b1 || sdepth !== 3'd0) begin errors++; $display("FAIL underflow: got %h unf=%b d=%0d expected %h unf=1 d=0", addr, stk_unf, sdepth, 10'(ERR_CAT * ROWS)); end
    endtask

    task automatic test_interrupts();
        idle();
        op_cat = 6'd5;
        int_rq = 3'b011; #1;
        checks++; if (intsrv !== 1'b1) begin errors++; $display("FAIL level_intsrv: got %b expected 1", intsrv); end
        ni = 1; step(); ni = 0;
        checks++; if (addr !== 10'h020 || cur_int !== 3'b010) begin errors++; $display("FAIL level_dispatch: got %h/%b expected 020/010", addr, cur_int); end
        int_rq = 0; step();
        checks++; if (cur_int !== 3'b010) begin errors++; $display("FAIL cur_int_hold: got %b expected 010", cur_int); end
        int_rq = 3'b100; step(); int_rq = 0; step(); #1;
        checks++; if (intsrv !== 1'b1) begin errors++; $display("FAIL edge_pending: got %b expected 1", intsrv); end
        ni = 1; step();
        checks++; if (addr !== 10'h030 || cur_int !== 3'b100) begin errors++; $display("FAIL edge_dispatch: got %h/%b expected 030/100", addr, cur_int); end
        step();
        checks++; if (addr !== 10'h050 || cur_int !== 3'b000) begin errors++; $display("FAIL edge_cleared: got %h/%b expected 050/000", addr, cur_int); end
        int_rq = 3'b100; step();
        checks++; if (addr !== 10'h050) begin errors++; $display("FAIL edge_same_cycle: got %h expected 050", addr); end
        int_rq = 0; step(); ni = 0;
        checks++; if (addr !== 10'h030 || cur_int !== 3'b100) begin errors++; $display("FAIL edge_next_ni: got %h/%b expected 030/100", addr, cur_int); end
    endtask

    task automatic test_mask();
        idle();
        op_cat = 6'd5;
        int_mask = 3'b100; int_rq = 3'b100; step(); int_rq = 0; #1;
        checks++; if (intsrv !== 1'b0) begin errors++; $display("FAIL masked_intsrv: got %b expected 0", intsrv); end
        ni = 1; step(); ni = 0;
        checks++; if (addr !== 10'h050 || cur_int !== 3'b000) begin errors++; $display("FAIL masked_ni: got %h/%b expected 050/000", addr, cur_int); end
        int_mask = 0; #1;
        checks++; if (intsrv !== 1'b1) begin errors++; $display("FAIL unmask_intsrv: got %b expected 1", intsrv); end
        ni = 1; step(); ni = 0;
        checks++; if (addr !== 10'h030 || cur_int !== 3'b100) begin errors++; $display("FAIL unmask_dispatch: got %h/%b expected 030/100", addr, cur_int); end
    endtask

    task automatic test_priority_stall();
        idle();
        op_cat = 6'd5;
        call = 1; call_cat = 6'd4; step(); call = 0;
        jmp = 1; jmp_cat = 6'd2; call = 1; call_cat = 6'd8; ret = 1; ni = 1; step();
        jmp = 0; call = 0; ret = 0; ni = 0;
        checks++; if (addr !== 10'h020 || sdepth !== 3'(m_stack.size()) || sdepth !== 3'd1) begin errors++; $display("FAIL jmp_priority: got %h d=%0d expected 020 d=1", addr, sdepth); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (addr !== 10'h020) begin errors++; $display("FAIL stall_hold%0d: got %h expected 020", i, addr); end
        end
        ni = 1; step(); ni = 0; stall = 0;
        checks++; if (addr !== 10'h050) begin errors++; $display("FAIL stall_ni: got %h expected 050", addr); end
        cen = 0; jmp = 1; jmp_cat = 6'd9; step(); jmp = 0; cen = 1;
        checks++; if (addr !== 10'h050) begin errors++; $display("FAIL cen_low: got %h expected 050", addr); end
    endtask

    task automatic test_halt();
        logic [9:0] a;
        logic [2:0] d;
        idle();
        op_cat = 6'd5;
        step();
        a = addr; d = sdepth;
        halt = 1; ni = 1; call = 1; int_rq = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (addr !== a || sdepth !== d) begin errors++; $display("FAIL halt_freeze%0d: got %h d=%0d expected %h d=%0d", i, addr, sdepth, a, d); end
        end
        int_rq = 0; halt = 0; ni = 0; call = 0; step();
        ni = 1; step(); ni = 0;
        checks++; if (addr !== 10'h050 || cur_int !== 3'b000) begin errors++; $display("FAIL halt_edge_gone: got %h/%b expected 050/000", addr, cur_int); end
        halt = 1; int_rq = 3'b100; step(); step();
        halt = 0; step();
        ni = 1; step(); ni = 0; int_rq = 0;
        checks++; if (addr !== 10'h030 || cur_int !== 3'b100) begin errors++; $display("FAIL halt_edge_kept: got %h/%b expected 030/100", addr, cur_int); end
    endtask

    task automatic test_random();
        logic exp_srv;
        idle();
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            cen   = rst ? 1'b1 : ($urandom_range(0, 9) != 0);
            halt  = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 2) == 0);
            jmp   = ($urandom_range(0, 19) == 0);
            call  = ($urandom_range(0, 6) == 0);
            ret   = ($urandom_range(0, 6) == 0);
            ni    = ($urandom_range(0, 4) == 0);
            op_cat   = 6'($urandom);
            jmp_cat  = 6'($urandom);
            call_cat = 6'($urandom);
            if ($urandom_range(0, 3) == 0) int_rq = 3'($urandom);
            if ($urandom_range(0, 15) == 0) int_mask = 3'($urandom);
            #1;
            exp_srv = |((m_pend | (int_rq & ~EDGE)) & ~int_mask);
            checks++; if (intsrv !== exp_srv) begin errors++; $display("FAIL rnd_intsrv@%0d: got %b expected %b", n, intsrv, exp_srv); end
            step();
            checks++; if (addr !== 10'(m_addr)) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", n, addr, 10'(m_addr)); end
            checks++; if (cur_int !== m_cur) begin errors++; $display("FAIL rnd_cur_int@%0d: got %b expected %b", n, cur_int, m_cur); end
            checks++; if (sdepth !== 3'(m_stack.size())) begin errors++; $display("FAIL rnd_sdepth@%0d: got %0d expected %0d", n, sdepth, m_stack.size()); end
            checks++; if (stk_ovf !== m_ovf || stk_unf !== m_unf) begin errors++; $display("FAIL rnd_flags@%0d: got %b%b expected %b%b", n, stk_ovf, stk_unf, m_ovf, m_unf); end
        end
    endtask

    initial begin
        op_cat = 0;
        idle();
        m_addr = 0; m_pend = 0; m_prev = 0; m_cur = 0; m_ovf = 0; m_unf = 0;
        test_reset();
        test_calls();
        test_interrupts();
        test_mask();
        test_priority_stall();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
